// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: default payload width and the stage state encoding.
// State is encoded directly as {main_valid, skid_valid}, so (0,1) never exists as a state.
package pipe_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'b00;
  localparam pipe_state_t ST_ONE   = 2'b10;
  localparam pipe_state_t ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Stage-to-stage link: upstream valid/ready/data into the stage and downstream valid/ready/data out.
// The slave modport is the stage itself; the master modport is the surrounding pipeline.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = XLEN
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register: async active-low reset and sync clear both load RST_VAL.
// Clear wins over load.
module pipe_data_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = RST_VAL;
    end else if (ld_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline register (main + skid) with a registered in_ready and sync flush.
// In-to-out latency is one cycle; a full stage deasserts in_ready until the main word drains.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  pipe_skid_stage_if.slave   bus,
  output logic [1:0]         occupancy
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_ld;
  logic             main_sel_skid;
  logic             skid_ld;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] main_d;

  // Both handshake outputs come straight from state flops, so out_ready never reaches in_ready.
  assign bus.out_valid = state_q[1];
  assign bus.in_ready  = ~state_q[0];
  assign bus.out_data  = main_q;
  assign occupancy     = {1'b0, state_q[1]} + {1'b0, state_q[0]};

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d       = state_q;
    main_ld       = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_d = ST_FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d       = ST_ONE;
          main_ld       = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_sel_skid ? skid_q : bus.in_data;

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(FLUSH_VAL)) u_main_reg (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RST_VAL(FLUSH_VAL)) u_skid_reg (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .ld_i  (skid_ld),
    .d_i   (bus.in_data),
    .q_o   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: inputs change and outputs are sampled on the falling edge.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam logic [31:0] FV = 32'hDEAD_BEEF;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  int         n_chk;
  int         n_fail;

  pipe_skid_stage_if #(.WIDTH(32)) bus ();

  pipe_skid_stage #(.WIDTH(32), .FLUSH_VAL(FV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, ir});
    chk({tag, ".occ"},       {30'd0, occupancy},     {30'd0, occ});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA5A5_0001;
    bus.out_ready = 1'b0;

    // Reset held with in_valid asserted
    repeat (2) @(negedge clk);
    chk_state("rst", 1'b0, 1'b1, 2'd0);
    chk("rst.data", bus.out_data, FV);
    rst = 1'b1;
    @(negedge clk);
    chk_state("first", 1'b1, 1'b1, 2'd1);
    chk("first.data", bus.out_data, 32'hA5A5_0001);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_state("drain0", 1'b0, 1'b1, 2'd0);

    // Streaming 1..16 at full rate
    for (int c = 0; c <= 17; c++) begin
      if (c >= 1 && c <= 16) begin
        chk_state("stream", 1'b1, 1'b1, 2'd1);
        chk("stream.data", bus.out_data, c);
      end else if (c == 17) begin
        chk_state("stream.end", 1'b0, 1'b1, 2'd0);
      end
      bus.in_valid = (c < 16);
      bus.in_data = c + 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;

    // Backpressure: fill to two, hold 0x33 upstream, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h11;
    @(negedge clk);
    chk_state("bp.one", 1'b1, 1'b1, 2'd1);
    bus.in_data = 32'h22;
    @(negedge clk);
    chk_state("bp.full", 1'b1, 1'b0, 2'd2);
    chk("bp.full.data", bus.out_data, 32'h11);
    bus.in_data = 32'h33;
    @(negedge clk);
    chk_state("bp.hold", 1'b1, 1'b0, 2'd2);
    chk("bp.hold.data", bus.out_data, 32'h11);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_state("bp.d22", 1'b1, 1'b1, 2'd1);
    chk("bp.d22.data", bus.out_data, 32'h22);
    @(negedge clk);
    chk_state("bp.d33", 1'b1, 1'b1, 2'd1);
    chk("bp.d33.data", bus.out_data, 32'h33);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_state("bp.empty", 1'b0, 1'b1, 2'd0);

    // Flush while FULL with 0x33 offered
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h11;
    @(negedge clk);
    bus.in_data = 32'h22;
    @(negedge clk);
    chk_state("fl.full", 1'b1, 1'b0, 2'd2);
    bus.in_data = 32'h33;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk_state("fl.after", 1'b0, 1'b1, 2'd0);
    chk("fl.after.data", bus.out_data, FV);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_state("fl.quiet", 1'b0, 1'b1, 2'd0);

    // Flush in ONE discards the word accepted in the same cycle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h60;
    @(negedge clk);
    bus.in_data = 32'h66;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk_state("fl1.after", 1'b0, 1'b1, 2'd0);
    chk("fl1.after.data", bus.out_data, FV);

    // Simultaneous push and pop in ONE
    bus.in_valid = 1'b1;
    bus.in_data = 32'h44;
    @(negedge clk);
    chk("sim.44", bus.out_data, 32'h44);
    bus.in_data = 32'h55;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_state("sim.55", 1'b1, 1'b1, 2'd1);
    chk("sim.55.data", bus.out_data, 32'h55);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_state("sim.empty", 1'b0, 1'b1, 2'd0);

    // Async reset while FULL, asserted between edges
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h11;
    @(negedge clk);
    bus.in_data = 32'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_state("ar.full", 1'b1, 1'b0, 2'd2);
    #2 rst = 1'b0;
    #1;
    chk_state("ar.async", 1'b0, 1'b1, 2'd0);
    chk("ar.async.data", bus.out_data, FV);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_state("ar.post", 1'b0, 1'b1, 2'd0);
      chk("ar.post.data", bus.out_data, FV);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
